// File: rtl/seg_display_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : seg_display_arbiter
// Description : Shares one 8-digit seven-segment display between two
//               requesters. The granted word is latched into disp_x with a
//               minimum hold time per grant, round-robin tie breaking and
//               blanking after a period of inactivity.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_display_arbiter #(
    parameter int unsigned HOLD_CYCLES = 50_000_000,
    parameter int unsigned IDLE_CYCLES = 500_000_000,
    parameter logic [31:0] BLANK_VALUE = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        req0,
    input  logic [31:0] data0,
    output logic        ack0,
    input  logic        req1,
    input  logic [31:0] data1,
    output logic        ack1,
    output logic [31:0] disp_x,
    output logic [1:0]  owner
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_OPEN = 2'd2
    } state_t;

    localparam logic [1:0]  C_OWN_NONE  = 2'b00;
    localparam logic [1:0]  C_OWN_0     = 2'b01;
    localparam logic [1:0]  C_OWN_1     = 2'b10;
    localparam logic [31:0] C_HOLD_LOAD = HOLD_CYCLES - 32'd1;
    localparam logic [31:0] C_IDLE_LAST = IDLE_CYCLES - 32'd1;

    // Registered state
    state_t      r_state;
    logic [31:0] r_hold_cnt;
    logic [31:0] r_idle_cnt;
    logic        r_last;      // 0: requester 0 was granted last, 1: requester 1
    logic        r_ack0;
    logic        r_ack1;
    logic [31:0] r_disp;
    logic [1:0]  r_owner;

    // Next-state values
    state_t      w_state_nxt;
    logic [31:0] w_hold_nxt;
    logic [31:0] w_idle_nxt;
    logic        w_last_nxt;
    logic [31:0] w_disp_nxt;
    logic [1:0]  w_owner_nxt;
    logic        w_take0;
    logic        w_take1;
    logic        w_arb;
    logic        w_blank;

    // A request is not re-accepted during its own ack cycle
    logic w_elig0;
    logic w_elig1;
    logic w_pick1;

    assign w_elig0 = req0 & ~r_ack0;
    assign w_elig1 = req1 & ~r_ack1;
    // On a tie the requester that was not granted last wins
    assign w_pick1 = w_elig1 & (~w_elig0 | ~r_last);

    // Next-state, counter and output-register computation
    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold_cnt;
        w_idle_nxt  = r_idle_cnt;
        w_last_nxt  = r_last;
        w_disp_nxt  = r_disp;
        w_owner_nxt = r_owner;
        w_take0     = 1'b0;
        w_take1     = 1'b0;
        w_arb       = 1'b0;
        w_blank     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_elig0 | w_elig1) begin
                    w_arb = 1'b1;
                end
            end
            ST_HOLD: begin
                // Only the current owner may refresh its word; the hold
                // window is not extended so the other side cannot starve.
                w_take0 = (r_owner == C_OWN_0) & w_elig0;
                w_take1 = (r_owner == C_OWN_1) & w_elig1;
                if (r_hold_cnt == 32'd0) begin
                    w_state_nxt = ST_OPEN;
                    w_idle_nxt  = 32'd0;
                end else begin
                    w_hold_nxt = r_hold_cnt - 32'd1;
                end
            end
            ST_OPEN: begin
                if (w_elig0 | w_elig1) begin
                    w_arb = 1'b1;
                end else if (r_idle_cnt == C_IDLE_LAST) begin
                    w_blank     = 1'b1;
                    w_state_nxt = ST_IDLE;
                    w_idle_nxt  = 32'd0;
                end else begin
                    w_idle_nxt = r_idle_cnt + 32'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_arb) begin
            w_take0     = ~w_pick1;
            w_take1     = w_pick1;
            w_state_nxt = ST_HOLD;
            w_hold_nxt  = C_HOLD_LOAD;
        end

        if (w_take0) begin
            w_disp_nxt  = data0;
            w_owner_nxt = C_OWN_0;
            w_last_nxt  = 1'b0;
        end else if (w_take1) begin
            w_disp_nxt  = data1;
            w_owner_nxt = C_OWN_1;
            w_last_nxt  = 1'b1;
        end else if (w_blank) begin
            w_disp_nxt  = BLANK_VALUE;
            w_owner_nxt = C_OWN_NONE;
        end
    end

    // State and output registers with synchronous clear
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state    <= ST_IDLE;
            r_hold_cnt <= 32'd0;
            r_idle_cnt <= 32'd0;
            r_last     <= 1'b1;
            r_ack0     <= 1'b0;
            r_ack1     <= 1'b0;
            r_disp     <= BLANK_VALUE;
            r_owner    <= C_OWN_NONE;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_idle_cnt <= w_idle_nxt;
            r_last     <= w_last_nxt;
            r_ack0     <= w_take0;
            r_ack1     <= w_take1;
            r_disp     <= w_disp_nxt;
            r_owner    <= w_owner_nxt;
        end
    end

    assign ack0   = r_ack0;
    assign ack1   = r_ack1;
    assign disp_x = r_disp;
    assign owner  = r_owner;

endmodule
`default_nettype wire
